// File: rtl/avalon_master_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_master_arbiter
//
// Purpose:
//   Shares one downstream Avalon master interface between two requesters.
//   The arbiter grants one requester, issues its command to the downstream
//   side for one cycle, and then waits for the downstream completion pulse.
//   It returns that completion, together with the read data, to the granted
//   requester. Ties go round-robin by default.
//
// Configuration macro:
//   ARB_FIXED_PRIORITY_EN - when defined, requester 0 always wins a tie and
//                           the round-robin pointer is not built.
//
// Ports:
//   clk, reset                      clock; synchronous active-high reset
//   sN_leer / sN_escribir           requester N read / write request (level)
//   sN_direccion                    requester N address
//   sN_datos_escribir               requester N write data
//   sN_datos_leidos                 last read data delivered to requester N
//   sN_completada                   one-cycle completion pulse to requester N
//   m_leer / m_escribir             downstream command (one cycle)
//   m_direccion, m_datos_escribir   downstream address / write data
//   m_datos_leidos                  downstream read data
//   m_transaccion_completada        downstream completion pulse
//   concesion                       one-hot grant (bit N = requester N)
// ---------------------------------------------------------------------------
// state    | meaning
// ---------+-------------------------------------------------------------
// E_LIBRE  | idle; no grant; choose a winner when any request is present
// E_EMITIR | single cycle; drive the winner's command downstream
// E_ESPERA | command withdrawn; wait for m_transaccion_completada
// ---------------------------------------------------------------------------
module avalon_master_arbiter #(
    parameter int DATA_BITS    = 8,
    parameter int ADDRESS_BITS = 5
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    s0_leer,
    input  logic                    s0_escribir,
    input  logic [ADDRESS_BITS-1:0] s0_direccion,
    input  logic [DATA_BITS-1:0]    s0_datos_escribir,
    output logic [DATA_BITS-1:0]    s0_datos_leidos,
    output logic                    s0_completada,

    input  logic                    s1_leer,
    input  logic                    s1_escribir,
    input  logic [ADDRESS_BITS-1:0] s1_direccion,
    input  logic [DATA_BITS-1:0]    s1_datos_escribir,
    output logic [DATA_BITS-1:0]    s1_datos_leidos,
    output logic                    s1_completada,

    output logic                    m_leer,
    output logic                    m_escribir,
    output logic [ADDRESS_BITS-1:0] m_direccion,
    output logic [DATA_BITS-1:0]    m_datos_escribir,
    input  logic [DATA_BITS-1:0]    m_datos_leidos,
    input  logic                    m_transaccion_completada,

    output logic [1:0]              concesion
);

    typedef enum logic [1:0] {
        E_LIBRE  = 2'b00,
        E_EMITIR = 2'b01,
        E_ESPERA = 2'b10
    } estado_t;

    estado_t estado;
    estado_t estado_sig;

    logic [1:0]           pendiente;
    logic                 ganador;
    logic                 fin;
    logic                 sel;
    logic                 sel_leer;
    logic                 sel_escribir;
    logic [DATA_BITS-1:0] hold0;
    logic [DATA_BITS-1:0] hold1;

    assign pendiente = {s1_leer | s1_escribir, s0_leer | s0_escribir};

    // concesion is one-hot whenever it is nonzero, so bit 1 alone selects
    // the granted requester.
    assign sel          = concesion[1];
    assign sel_leer     = sel ? s1_leer     : s0_leer;
    assign sel_escribir = sel ? s1_escribir : s0_escribir;

    // A completion counts only while a command is outstanding.
    assign fin = (estado == E_ESPERA) && m_transaccion_completada;

`ifdef ARB_FIXED_PRIORITY_EN
    assign ganador = ~pendiente[0];
`else
    logic ultimo;

    always_comb begin
        if (&pendiente) begin
            ganador = ~ultimo;
        end else begin
            ganador = ~pendiente[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ultimo <= 1'b1;
        end else if (estado == E_LIBRE && |pendiente) begin
            ultimo <= ganador;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= E_LIBRE;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_sig = E_LIBRE;
        case (estado)
            E_LIBRE:  estado_sig = (|pendiente) ? E_EMITIR : E_LIBRE;
            E_EMITIR: estado_sig = E_ESPERA;
            E_ESPERA: estado_sig = m_transaccion_completada ? E_LIBRE : E_ESPERA;
            default:  estado_sig = E_LIBRE;
        endcase
    end

    // Grant and read-data hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            concesion <= 2'b00;
            hold0     <= '0;
            hold1     <= '0;
        end else begin
            if (estado == E_LIBRE && |pendiente) begin
                concesion <= ganador ? 2'b10 : 2'b01;
            end else if (estado_sig == E_LIBRE) begin
                concesion <= 2'b00;
            end

            if (fin && !sel) begin
                hold0 <= m_datos_leidos;
            end
            if (fin && sel) begin
                hold1 <= m_datos_leidos;
            end
        end
    end

    // Output logic.
    always_comb begin
        m_leer           = 1'b0;
        m_escribir       = 1'b0;
        m_direccion      = '0;
        m_datos_escribir = '0;
        s0_completada    = 1'b0;
        s1_completada    = 1'b0;
        s0_datos_leidos  = hold0;
        s1_datos_leidos  = hold1;

        case (estado)
            E_EMITIR: begin
                // A simultaneous read and write is issued as a write.
                m_leer           = sel_leer & ~sel_escribir;
                m_escribir       = sel_escribir;
                m_direccion      = sel ? s1_direccion      : s0_direccion;
                m_datos_escribir = sel ? s1_datos_escribir : s0_datos_escribir;
            end
            E_ESPERA: begin
                m_direccion      = sel ? s1_direccion      : s0_direccion;
                m_datos_escribir = sel ? s1_datos_escribir : s0_datos_escribir;
                if (fin) begin
                    if (sel) begin
                        s1_completada   = 1'b1;
                        s1_datos_leidos = m_datos_leidos;
                    end else begin
                        s0_completada   = 1'b1;
                        s0_datos_leidos = m_datos_leidos;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avalon_master_arbiter
//
// Scoreboard bench for avalon_master_arbiter. Stimulus pushes the expected
// downstream commands and requester completions into queues; a monitor on
// the falling edge pops and compares whenever the DUT issues a command or a
// completion. A downstream responder model returns completions a
// programmable number of cycles after each command.
// ---------------------------------------------------------------------------
module tb_avalon_master_arbiter;

    localparam int DW = 8;
    localparam int AW = 5;

    typedef struct packed {
        logic [1:0]    gnt;
        logic          leer;
        logic          esc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic          idx;
        logic [DW-1:0] data;
    } cpl_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s0_leer = 1'b0, s0_escribir = 1'b0;
    logic [AW-1:0] s0_direccion = '0;
    logic [DW-1:0] s0_datos_escribir = '0;
    logic [DW-1:0] s0_datos_leidos;
    logic          s0_completada;
    logic          s1_leer = 1'b0, s1_escribir = 1'b0;
    logic [AW-1:0] s1_direccion = '0;
    logic [DW-1:0] s1_datos_escribir = '0;
    logic [DW-1:0] s1_datos_leidos;
    logic          s1_completada;
    logic          m_leer, m_escribir;
    logic [AW-1:0] m_direccion;
    logic [DW-1:0] m_datos_escribir;
    logic [DW-1:0] m_datos_leidos = '0;
    logic          m_transaccion_completada = 1'b0;
    logic [1:0]    concesion;

    // Responder controls, written only by the stimulus process.
    int            dly = 1;
    logic [DW-1:0] rd_val = '0;
    logic          spur_libre = 1'b0;
    logic          spur_emitir = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    cmd_t cmd_q[$];
    cpl_t cpl_q[$];

    avalon_master_arbiter #(.DATA_BITS(DW), .ADDRESS_BITS(AW)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .s0_leer                  (s0_leer),
        .s0_escribir              (s0_escribir),
        .s0_direccion             (s0_direccion),
        .s0_datos_escribir        (s0_datos_escribir),
        .s0_datos_leidos          (s0_datos_leidos),
        .s0_completada            (s0_completada),
        .s1_leer                  (s1_leer),
        .s1_escribir              (s1_escribir),
        .s1_direccion             (s1_direccion),
        .s1_datos_escribir        (s1_datos_escribir),
        .s1_datos_leidos          (s1_datos_leidos),
        .s1_completada            (s1_completada),
        .m_leer                   (m_leer),
        .m_escribir               (m_escribir),
        .m_direccion              (m_direccion),
        .m_datos_escribir         (m_datos_escribir),
        .m_datos_leidos           (m_datos_leidos),
        .m_transaccion_completada (m_transaccion_completada),
        .concesion                (concesion)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Downstream responder: sees the command at #2 of the EMITIR cycle and
    // pulses completion dly cycles later.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            m_transaccion_completada = 1'b0;
            if (reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        m_transaccion_completada = 1'b1;
                        m_datos_leidos = rd_val;
                    end
                end
                if (m_leer || m_escribir) begin
                    cnt = dly;
                    if (spur_emitir) begin
                        m_transaccion_completada = 1'b1;
                        m_datos_leidos = 8'h77;
                    end
                end else if (spur_libre) begin
                    m_transaccion_completada = 1'b1;
                    m_datos_leidos = 8'hEE;
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        cmd_t ec;
        cpl_t ep;
        forever begin
            @(negedge clk);
            if (m_leer || m_escribir) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {30'd0, m_leer, m_escribir}, 32'd0);
                end else begin
                    ec = cmd_q.pop_front();
                    chk("cmd_concesion", {30'd0, concesion}, {30'd0, ec.gnt});
                    chk("cmd_m_leer", {31'd0, m_leer}, {31'd0, ec.leer});
                    chk("cmd_m_escribir", {31'd0, m_escribir}, {31'd0, ec.esc});
                    chk("cmd_m_direccion", {27'd0, m_direccion}, {27'd0, ec.addr});
                    chk("cmd_m_datos_escribir", {24'd0, m_datos_escribir}, {24'd0, ec.data});
                end
            end
            if (s0_completada || s1_completada) begin
                if (cpl_q.size() == 0) begin
                    chk("unexpected_cpl", {30'd0, s1_completada, s0_completada}, 32'd0);
                end else begin
                    ep = cpl_q.pop_front();
                    chk("cpl_owner", {30'd0, s1_completada, s0_completada},
                        ep.idx ? 32'd2 : 32'd1);
                    chk("cpl_datos_leidos",
                        {24'd0, (ep.idx ? s1_datos_leidos : s0_datos_leidos)},
                        {24'd0, ep.data});
                end
            end
            if (concesion == 2'b00) begin
                chk("libre_m_bus_zero", {19'd0, m_direccion, m_datos_escribir}, 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        s0_leer = 1'b0; s0_escribir = 1'b0; s1_leer = 1'b0; s1_escribir = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_concesion", {30'd0, concesion}, 32'd0);
        chk("rst_m_cmd", {30'd0, m_leer, m_escribir}, 32'd0);
        chk("rst_m_bus", {19'd0, m_direccion, m_datos_escribir}, 32'd0);
        chk("rst_completada", {30'd0, s1_completada, s0_completada}, 32'd0);
        chk("rst_hold", {16'd0, s1_datos_leidos, s0_datos_leidos}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_cmd();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_leer || m_escribir) return;
        end
        chk("timeout_cmd", 32'd1, 32'd0);
    endtask

    task automatic wait_completions(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < 200 && seen < n; i++) begin
            @(negedge clk);
            if (s0_completada || s1_completada) seen++;
        end
        if (seen < n) chk("timeout_cpl", seen, n);
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, "_cmd_q_left"}, cmd_q.size(), 0);
        chk({tag, "_cpl_q_left"}, cpl_q.size(), 0);
    endtask

    initial begin
        // ---- Single s0 read, completion two cycles after EMITIR ----
        do_reset();
        dly = 2; rd_val = 8'hA5;
        s0_datos_escribir = 8'h9C; s1_datos_escribir = 8'h44;
        cmd_q.push_back('{gnt: 2'b01, leer: 1'b1, esc: 1'b0, addr: 5'h03, data: 8'h9C});
        cpl_q.push_back('{idx: 1'b0, data: 8'hA5});
        s0_direccion = 5'h03; s0_leer = 1'b1;
        wait_completions(1);
        @(posedge clk); #1; s0_leer = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_s0_hold", {24'd0, s0_datos_leidos}, 32'h0000_00A5);
        chk("t1_s1_hold", {24'd0, s1_datos_leidos}, 32'd0);
        chk("t1_concesion_idle", {30'd0, concesion}, 32'd0);
        queues_empty("t1");

        // ---- Both write continuously: grant order ----
        do_reset();
        dly = 1; rd_val = 8'h5A;
        s0_direccion = 5'h01; s0_datos_escribir = 8'h11;
        s1_direccion = 5'h02; s1_datos_escribir = 8'h22;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < 3; k++) begin
            cmd_q.push_back('{gnt: 2'b01, leer: 1'b0, esc: 1'b1, addr: 5'h01, data: 8'h11});
            cpl_q.push_back('{idx: 1'b0, data: 8'h5A});
        end
        s0_escribir = 1'b1; s1_escribir = 1'b1;
        wait_completions(3);
`else
        for (int k = 0; k < 2; k++) begin
            cmd_q.push_back('{gnt: 2'b01, leer: 1'b0, esc: 1'b1, addr: 5'h01, data: 8'h11});
            cpl_q.push_back('{idx: 1'b0, data: 8'h5A});
            cmd_q.push_back('{gnt: 2'b10, leer: 1'b0, esc: 1'b1, addr: 5'h02, data: 8'h22});
            cpl_q.push_back('{idx: 1'b1, data: 8'h5A});
        end
        s0_escribir = 1'b1; s1_escribir = 1'b1;
        wait_completions(4);
`endif
        @(posedge clk); #1; s0_escribir = 1'b0; s1_escribir = 1'b0;
        repeat (4) @(negedge clk);
        queues_empty("t2");

        // ---- s1 read and write together: treated as a write ----
        do_reset();
        dly = 1; rd_val = 8'h66;
        s1_direccion = 5'h1F; s1_datos_escribir = 8'h3C;
        cmd_q.push_back('{gnt: 2'b10, leer: 1'b0, esc: 1'b1, addr: 5'h1F, data: 8'h3C});
        cpl_q.push_back('{idx: 1'b1, data: 8'h66});
        s1_leer = 1'b1; s1_escribir = 1'b1;
        wait_completions(1);
        @(posedge clk); #1; s1_leer = 1'b0; s1_escribir = 1'b0;
        repeat (2) @(negedge clk);
        chk("t3_s1_hold", {24'd0, s1_datos_leidos}, 32'h0000_0066);
        queues_empty("t3");

        // ---- Spurious completions in E_LIBRE and E_EMITIR ----
        do_reset();
        @(posedge clk); #1; spur_libre = 1'b1;
        @(posedge clk); #1; spur_libre = 1'b0;
        @(negedge clk);
        chk("t4_libre_hold", {16'd0, s1_datos_leidos, s0_datos_leidos}, 32'd0);
        chk("t4_libre_concesion", {30'd0, concesion}, 32'd0);
        dly = 2; rd_val = 8'h3C; spur_emitir = 1'b1;
        s0_direccion = 5'h04; s0_datos_escribir = 8'h81;
        cmd_q.push_back('{gnt: 2'b01, leer: 1'b1, esc: 1'b0, addr: 5'h04, data: 8'h81});
        cpl_q.push_back('{idx: 1'b0, data: 8'h3C});
        @(posedge clk); #1; s0_leer = 1'b1;
        wait_cmd();
        spur_emitir = 1'b0;
        @(negedge clk);
        chk("t4_still_espera", {30'd0, concesion}, 32'd1);
        chk("t4_emitir_hold", {24'd0, s0_datos_leidos}, 32'd0);
        wait_completions(1);
        @(posedge clk); #1; s0_leer = 1'b0;
        @(negedge clk);
        chk("t4_final_hold", {24'd0, s0_datos_leidos}, 32'h0000_003C);
        chk("t4_back_libre", {30'd0, concesion}, 32'd0);
        queues_empty("t4");

        // ---- Reset during E_ESPERA of an s1 read, then a tie ----
        do_reset();
        dly = 5; rd_val = 8'hC3;
        s1_direccion = 5'h07; s1_datos_escribir = 8'h5B;
        cmd_q.push_back('{gnt: 2'b10, leer: 1'b1, esc: 1'b0, addr: 5'h07, data: 8'h5B});
        s1_leer = 1'b1;
        wait_cmd();
        @(posedge clk); #1; reset = 1'b1; s1_leer = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_rst_concesion", {30'd0, concesion}, 32'd0);
        chk("t5_rst_m_cmd", {30'd0, m_leer, m_escribir}, 32'd0);
        chk("t5_rst_m_bus", {19'd0, m_direccion, m_datos_escribir}, 32'd0);
        chk("t5_rst_hold", {24'd0, s1_datos_leidos}, 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        dly = 2;
        s0_direccion = 5'h08; s0_datos_escribir = 8'hA0;
        s1_direccion = 5'h09; s1_datos_escribir = 8'hB0;
        cmd_q.push_back('{gnt: 2'b01, leer: 1'b1, esc: 1'b0, addr: 5'h08, data: 8'hA0});
        cpl_q.push_back('{idx: 1'b0, data: 8'hC3});
        cmd_q.push_back('{gnt: 2'b10, leer: 1'b1, esc: 1'b0, addr: 5'h09, data: 8'hB0});
        cpl_q.push_back('{idx: 1'b1, data: 8'hC3});
        s0_leer = 1'b1; s1_leer = 1'b1;
        wait_completions(1);
        @(posedge clk); #1; s0_leer = 1'b0;
        wait_completions(1);
        @(posedge clk); #1; s1_leer = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_s0_hold", {24'd0, s0_datos_leidos}, 32'h0000_00C3);
        chk("t5_s1_hold", {24'd0, s1_datos_leidos}, 32'h0000_00C3);
        queues_empty("t5");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/avalon_master_arbiter.md
AVALON_MASTER_ARBITER -- requirements
Module: avalon_master_arbiter

Interface
REQ-001 Parameter DATA_BITS, default 8, width of the write and read data buses.
REQ-002 Parameter ADDRESS_BITS, default 5, width of the address buses.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s0_leer, s1_leer  input  1 each  requester n read request (level).
REQ-006 s0_escribir, s1_escribir  input  1 each  requester n write request (level).
REQ-007 s0_direccion, s1_direccion  input  ADDRESS_BITS each  requester n address.
REQ-008 s0_datos_escribir, s1_datos_escribir  input  DATA_BITS each  requester n write data.
REQ-009 s0_datos_leidos, s1_datos_leidos  output  DATA_BITS each  last read data delivered to requester n.
REQ-010 s0_completada, s1_completada  output  1 each  one-cycle completion pulse to requester n.
REQ-011 m_leer, m_escribir  output  1 each  command to the downstream Avalon master interface.
REQ-012 m_direccion  output  ADDRESS_BITS  address to the downstream interface.
REQ-013 m_datos_escribir  output  DATA_BITS  write data to the downstream interface.
REQ-014 m_datos_leidos  input  DATA_BITS  read data from the downstream interface.
REQ-015 m_transaccion_completada  input  1  completion pulse from the downstream interface.
REQ-016 concesion  output  2  one-hot grant: bit n set while requester n owns the downstream interface.

Function
REQ-017 A requester asserts leer or escribir and holds the command, address and data stable until it samples its completada high, then deasserts on that same edge.
REQ-018 If a requester asserts both leer and escribir, the arbiter treats the request as a write only (m_leer=0).
REQ-019 FSM states are E_LIBRE, E_EMITIR and E_ESPERA; any illegal encoding returns to E_LIBRE on the next edge.
REQ-020 E_LIBRE: when any request is present, latch the winner into concesion and move to E_EMITIR on the next edge; otherwise remain in E_LIBRE.
REQ-021 E_EMITIR lasts exactly one cycle: m_leer/m_escribir equal the winner's command, then move to E_ESPERA.
REQ-022 E_ESPERA: m_leer=m_escribir=0; the arbiter moves to E_LIBRE on the edge where m_transaccion_completada=1.
REQ-023 In E_EMITIR and E_ESPERA, m_direccion and m_datos_escribir pass through the granted requester's inputs; in E_LIBRE both are 0.
REQ-024 In the cycle m_transaccion_completada=1 during E_ESPERA, the granted sn_completada=1 combinationally and sn_datos_leidos=m_datos_leidos; the arbiter registers this value into that requester's hold register.
REQ-025 Outside the cycle in REQ-024, sn_datos_leidos shows the hold register of requester n.
REQ-026 A completion pulse received in E_LIBRE or E_EMITIR is ignored: no completada pulse and no register update.
REQ-027 Round-robin: the arbiter keeps pointer ultimo (last granted index); when both requesters are pending, it grants the one not equal to ultimo.
REQ-028 ultimo updates on entry to E_EMITIR.
REQ-029 A single pending requester is granted regardless of ultimo.
REQ-030 Minimum spacing between back-to-back grants is one E_LIBRE cycle.
REQ-031 concesion is 2'b00 in E_LIBRE.

Reset
REQ-032 While reset=1 at an edge, the arbiter enters E_LIBRE and sets ultimo=1 (requester 0 wins the first tie).
REQ-033 While reset=1 at an edge, concesion=0, m_leer=m_escribir=0, m_direccion=0, m_datos_escribir=0, s0/s1_completada=0, and both hold registers are 0.
REQ-034 Reset mid-transaction abandons the grant immediately; the downstream interface is driven from the same reset (reset_n = ~reset).

Configuration
REQ-035 Macro ARB_FIXED_PRIORITY_EN: when defined, requester 0 always wins ties and ultimo is not implemented; when undefined, round-robin per REQ-027 to REQ-029 applies.

Verification
REQ-036 Reset, then s0 read at addr 5'h03; downstream completes with data 8'hA5 two cycles after E_EMITIR -> m_leer high exactly one cycle, s0_completada one pulse, s0_datos_leidos=8'hA5 and held afterwards, s1 outputs unchanged.
REQ-037 s0 and s1 both write (data 8'h11 / 8'h22) from reset, each re-requesting immediately after its completion -> grant order s0,s1,s0,s1 and m_datos_escribir matches the grant; with ARB_FIXED_PRIORITY_EN the order is s0,s0,s0.
REQ-038 s1 asserts leer and escribir together, addr 5'h1F -> m_escribir=1, m_leer=0, m_direccion=5'h1F.
REQ-039 Spurious m_transaccion_completada in E_LIBRE and in E_EMITIR -> no completada pulse, no hold-register change, FSM sequence unaffected.
REQ-040 reset asserted during E_ESPERA of an s1 read -> next cycle concesion=0 and all m_* outputs 0; a subsequent tie is granted to s0.
